intc_prio_arb: RTL and testbench
================================

Name: intc_prio_arb

Overview:
- Parametrised, registered successor to the fixed 27-channel combinational interrupt priority decoder.
- Channels are grouped into NUM_BUS buses of CHAN_PER_BUS channels each. Each channel has a sticky pending latch and an enable mask.
- The block selects the highest-priority eligible pending channel and presents its ID on a valid/ack handshake. The interrupt source clears on ack.
- Sits between raw peripheral interrupt lines and the CPU interrupt interface.

Parameters:
- NUM_BUS, 3, number of buses; bus 0 has the highest priority.
- CHAN_PER_BUS, 9, channels per bus; within a bus, channel 0 has the highest priority.
- NCH (localparam), NUM_BUS*CHAN_PER_BUS, total channel count.
- IDW (localparam), $clog2(NCH), width of the flat channel ID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- irq_req  in  NCH  raw interrupt lines; bit i = bus i/CHAN_PER_BUS, channel i%CHAN_PER_BUS.
- irq_en  in  NCH  per-channel enable mask.
- bus_en  in  NUM_BUS  per-bus enable.
- irq_ack  in  1  consumer accepts the presented interrupt.
- irq_valid  out  1  an interrupt is being presented.
- irq_id  out  IDW  flat ID = bus*CHAN_PER_BUS + chan.
- irq_bus  out  max(1,$clog2(NUM_BUS))  winning bus.
- bus_pend  out  NUM_BUS  registered per-bus OR of eligible pending bits.
- pending  out  NCH  pending latch contents.

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset: pending=0, state=IDLE, irq_valid=0, irq_id=0, irq_bus=0, bus_pend=0.
- Eligibility: eligible[i] = pending[i] & irq_en[i] & bus_en[i/CHAN_PER_BUS].
- Capture: each cycle, pending[i] <= pending[i] | set[i]. Without the optional feature, set[i] = irq_req[i].
- Pending is never cleared by deasserting irq_req or irq_en. Masking only blocks selection.
- Selection: two-level fixed priority. Lowest-index bus with any eligible bit wins, then lowest-index eligible channel within that bus.
- bus_pend: registered every cycle from the eligible vector, regardless of state.
- State machine (states IDLE, PRESENT):
  - IDLE: if any eligible bit is set, register the winner into irq_id/irq_bus, set irq_valid=1 and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: irq_valid, irq_id and irq_bus are held stable until irq_ack. There is no pre-emption by higher-priority arrivals, and no retraction if the winner's mask drops.
  - PRESENT with irq_ack=1: clear pending[irq_id], set irq_valid=0, go to IDLE.
- Latency: irq_req high at edge k sets pending at k. irq_valid rises at edge k+1. Back-to-back grants occur at most every 2 cycles, because IDLE always lasts at least one cycle.
- Simultaneous set and clear on the same bit in the ack cycle: set wins, so the bit remains pending.
- irq_ack while in IDLE is ignored.
- rst asserted while in PRESENT: the presented interrupt is dropped, and its pending bit clears along with all others.

Optional Feature:
- Macro: INTC_EDGE_EN.
- Defined: a registered copy irq_req_q is kept (reset 0), and set[i] = irq_req[i] & ~irq_req_q[i]. Only rising edges latch pending, so a line held high pends exactly once.
- Undefined: level-sticky capture as described above; a line still high after ack re-pends immediately.

Decomposition:
- Package intc_pkg: state enum (IDLE, PRESENT), and a function computing IDW and bus-index width from NUM_BUS/CHAN_PER_BUS.
- Sub-module intc_ffs: parametrised find-first-set with outputs found and index. Instantiated once per bus and once across the per-bus found bits.

Test Plan:
- Reset, then irq_req[5]=1 for one cycle with all enables set -> pending[5]=1; irq_valid=1 one cycle later with irq_id=5, irq_bus=0; held until ack; after ack, pending[5]=0.
- irq_req[20] and irq_req[12] asserted in the same cycle -> irq_id=12 presented first; after ack and one IDLE cycle, irq_id=20, irq_bus=2.
- During PRESENT of irq_id=20, assert irq_req[0] -> irq_id stays 20 until ack; next grant is irq_id=0.
- Set irq_en[3]=0 with irq_req[3] pulsed -> pending[3]=1, bus_pend[0]=0, no irq_valid; raise irq_en[3] -> irq_id=3 presented.
- Hold irq_req[9] high across an ack -> level build: pending[9] stays 1 and irq_id=9 re-presents; INTC_EDGE_EN build: pending[9]=0, no re-presentation.
- Assert rst while in PRESENT with pending=27'h7FFFFFF -> next cycle: irq_valid=0, pending=0, bus_pend=0.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and width helpers for the interrupt priority arbiter.
package intc_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } intc_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned intc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned intc_id_w(input int unsigned nb, input int unsigned cpb);
    return intc_idx_w(nb * cpb);
  endfunction

  function automatic int unsigned intc_bus_w(input int unsigned nb);
    return intc_idx_w(nb);
  endfunction

endpackage

// File: rtl/intc_ffs.sv
// Parametrised find-first-set: lowest set bit of vec wins.
module intc_ffs #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = |vec;
    index = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/intc_prio_arb.sv
// Registered two-level fixed-priority interrupt arbiter with sticky pending latches.
// Define INTC_EDGE_EN to latch pending only on rising edges of irq_req.
module intc_prio_arb
  import intc_pkg::*;
#(
  parameter  int unsigned NUM_BUS      = 3,
  parameter  int unsigned CHAN_PER_BUS = 9,
  localparam int unsigned NCH          = NUM_BUS * CHAN_PER_BUS,
  localparam int unsigned IDW          = intc_id_w(NUM_BUS, CHAN_PER_BUS),
  localparam int unsigned BW           = intc_bus_w(NUM_BUS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     irq_req,
  input  logic [NCH-1:0]     irq_en,
  input  logic [NUM_BUS-1:0] bus_en,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [IDW-1:0]     irq_id,
  output logic [BW-1:0]      irq_bus,
  output logic [NUM_BUS-1:0] bus_pend,
  output logic [NCH-1:0]     pending
);

  localparam int unsigned CW = intc_idx_w(CHAN_PER_BUS);

  logic [NCH-1:0]     pending_q, pending_d;
  logic [NCH-1:0]     set_vec, clr_vec, bus_mask, elig;
  logic [NUM_BUS-1:0] bus_found;
  logic [NUM_BUS-1:0] bus_pend_q, bus_pend_d;
  logic [CW-1:0]      chan_idx [NUM_BUS];
  logic               any_elig;
  logic [BW-1:0]      win_bus;
  logic [CW-1:0]      win_chan;
  logic [IDW-1:0]     win_id;

  intc_state_e        state_q, state_d;
  logic               irq_valid_q, irq_valid_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic [BW-1:0]      irq_bus_q, irq_bus_d;

`ifdef INTC_EDGE_EN
  logic [NCH-1:0] irq_req_q, irq_req_d;

  assign irq_req_d = irq_req;
  assign set_vec   = irq_req & ~irq_req_q;

  always_ff @(posedge clk) begin
    if (rst) irq_req_q <= '0;
    else     irq_req_q <= irq_req_d;
  end
`else
  assign set_vec = irq_req;
`endif

  // Per-bus channel search plus the per-bus enable spread over each bus slice.
  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    assign bus_mask[b*CHAN_PER_BUS +: CHAN_PER_BUS] = {CHAN_PER_BUS{bus_en[b]}};

    intc_ffs #(
      .W  (CHAN_PER_BUS),
      .IW (CW)
    ) u_ffs_chan (
      .vec   (elig[b*CHAN_PER_BUS +: CHAN_PER_BUS]),
      .found (bus_found[b]),
      .index (chan_idx[b])
    );
  end

  assign elig = pending_q & irq_en & bus_mask;

  intc_ffs #(
    .W  (NUM_BUS),
    .IW (BW)
  ) u_ffs_bus (
    .vec   (bus_found),
    .found (any_elig),
    .index (win_bus)
  );

  always_comb begin
    win_chan = '0;
    for (int b = 0; b < int'(NUM_BUS); b++) begin
      if (win_bus == BW'(b)) win_chan = chan_idx[b];
    end
    win_id = IDW'(win_bus) * IDW'(CHAN_PER_BUS) + IDW'(win_chan);
  end

  // Next-state, pending update and presented-interrupt registers; set beats clear.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_bus_d   = irq_bus_q;
    clr_vec     = '0;
    bus_pend_d  = bus_found;

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          irq_id_d    = win_id;
          irq_bus_d   = win_bus;
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          for (int i = 0; i < int'(NCH); i++) begin
            if (irq_id_q == IDW'(i)) clr_vec[i] = 1'b1;
          end
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_bus_q   <= '0;
      bus_pend_q  <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_bus_q   <= irq_bus_d;
      bus_pend_q  <= bus_pend_d;
      pending_q   <= pending_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign irq_bus   = irq_bus_q;
  assign bus_pend  = bus_pend_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_intc_prio_arb.sv
// Directed self-checking bench for intc_prio_arb (default 3 buses x 9 channels).
module tb_intc_prio_arb;

  localparam int unsigned NCH = 27;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  irq_req;
  logic [NCH-1:0]  irq_en;
  logic [2:0]      bus_en;
  logic            irq_ack;
  logic            irq_valid;
  logic [4:0]      irq_id;
  logic [1:0]      irq_bus;
  logic [2:0]      bus_pend;
  logic [NCH-1:0]  pending;

  int checks   = 0;
  int failures = 0;

  intc_prio_arb u_dut (
    .clk       (clk),
    .rst       (rst),
    .irq_req   (irq_req),
    .irq_en    (irq_en),
    .bus_en    (bus_en),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_bus   (irq_bus),
    .bus_pend  (bus_pend),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input string tag, input int id, input int bus);
    chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
    chk({tag, "_id"},    32'(irq_id),    32'(id));
    chk({tag, "_bus"},   32'(irq_bus),   32'(bus));
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    irq_req = '0;
    irq_en  = '1;
    bus_en  = '1;
    irq_ack = 1'b0;
    tick();
    tick();
    chk("rst_valid",    32'(irq_valid), 32'd0);
    chk("rst_id",       32'(irq_id),    32'd0);
    chk("rst_bus",      32'(irq_bus),   32'd0);
    chk("rst_pending",  32'(pending),   32'd0);
    chk("rst_bus_pend", 32'(bus_pend),  32'd0);
    rst = 1'b0;
    tick();

    // Single request on channel 5: pends at edge k, presented at edge k+1.
    irq_req = 27'h20;
    tick();
    irq_req = '0;
    chk("t1_pend_k",  32'(pending),   32'h20);
    chk("t1_valid_k", 32'(irq_valid), 32'd0);
    tick();
    present("t1_k1", 5, 0);
    chk("t1_bus_pend", 32'(bus_pend), 32'h1);
    tick();
    present("t1_hold", 5, 0);
    ack_once();
    chk("t1_ack_valid", 32'(irq_valid), 32'd0);
    chk("t1_ack_pend",  32'(pending),   32'd0);

    // Channels 20 and 12 together: bus 1 beats bus 2.
    irq_req = 27'h101000;
    tick();
    irq_req = '0;
    tick();
    present("t2_first", 12, 1);
    ack_once();
    chk("t2_ack_valid", 32'(irq_valid), 32'd0);
    chk("t2_ack_pend",  32'(pending),   32'h100000);
    tick();
    present("t2_second", 20, 2);

    // Higher-priority arrival during PRESENT does not pre-empt.
    irq_req = 27'h1;
    tick();
    irq_req = '0;
    tick();
    present("t3_nopreempt", 20, 2);
    chk("t3_pend", 32'(pending), 32'h100001);
    ack_once();
    tick();
    present("t3_next", 0, 0);
    ack_once();
    chk("t3_pend_clr", 32'(pending), 32'd0);

    // Masked channel 3 pends but is not eligible; ack in IDLE is ignored.
    irq_en[3] = 1'b0;
    irq_req   = 27'h8;
    tick();
    irq_req = '0;
    tick();
    tick();
    chk("t4_pend",     32'(pending),   32'h8);
    chk("t4_bus_pend", 32'(bus_pend),  32'h0);
    chk("t4_valid",    32'(irq_valid), 32'd0);
    ack_once();
    chk("t4_idle_ack_pend", 32'(pending), 32'h8);
    irq_en[3] = 1'b1;
    tick();
    present("t4_unmask", 3, 0);
    chk("t4_unmask_bus_pend", 32'(bus_pend), 32'h1);
    ack_once();

    // Bus enable: bus 1 disabled lets bus 2 win first.
    bus_en  = 3'b101;
    irq_req = 27'h100400;
    tick();
    irq_req = '0;
    tick();
    present("t5_busmask", 20, 2);
    chk("t5_bus_pend", 32'(bus_pend), 32'h4);
    ack_once();
    bus_en = 3'b111;
    tick();
    present("t5_busunmask", 10, 1);
    ack_once();

    // Line held high across the ack.
    irq_req = 27'h200;
    tick();
    tick();
    present("t6_first", 9, 1);
    ack_once();
    chk("t6_ack_valid", 32'(irq_valid), 32'd0);
`ifdef INTC_EDGE_EN
    chk("t6_ack_pend", 32'(pending), 32'h0);
    tick();
    chk("t6_no_repres", 32'(irq_valid), 32'd0);
`else
    chk("t6_ack_pend", 32'(pending), 32'h200);
    tick();
    present("t6_repres", 9, 1);
`endif
    irq_req = '0;
    ack_once();
    chk("t6_clean_pend",  32'(pending),   32'd0);
    chk("t6_clean_valid", 32'(irq_valid), 32'd0);

    // Reset while presenting with every channel pending.
    irq_req = '1;
    tick();
    irq_req = '0;
    tick();
    present("t7_pre", 0, 0);
    chk("t7_pend_all", 32'(pending), 32'h7FFFFFF);
    rst = 1'b1;
    tick();
    chk("t7_rst_valid",    32'(irq_valid), 32'd0);
    chk("t7_rst_pend",     32'(pending),   32'd0);
    chk("t7_rst_bus_pend", 32'(bus_pend),  32'd0);
    rst = 1'b0;
    tick();
    chk("t7_post_valid", 32'(irq_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
